// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_mem_pkg
// Description : Shared definitions for the MEM-stage SRAM controller.
//               Holds the SRAM geometry, the default byte base address,
//               the controller FSM encoding and the byte-to-word address
//               mapping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_mem_pkg;

    localparam int          SRAM_ADDR_W       = 18;
    localparam int          SRAM_DATA_W       = 16;
    localparam int          CPU_DATA_W        = 32;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    // Wide enough for the largest legal WAIT_CYCLES (15).
    localparam int          WAIT_CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_t;

    // 32-bit word index inside the SRAM. The subtraction wraps modulo 2^32
    // and everything above the SRAM size is dropped, so out-of-range
    // addresses alias silently; byte-offset bits [1:0] are discarded.
    function automatic logic [SRAM_ADDR_W-2:0] sram_word_index(
        input logic [31:0] byte_addr,
        input logic [31:0] base
    );
        return (SRAM_ADDR_W-1)'((byte_addr - base) >> 2);
    endfunction

endpackage : arm_mem_pkg
`default_nettype wire

// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller_if
// Description : Bundle of the pipeline-side request/response signals and
//               the external SRAM pins of the SRAM controller.
//   Pipeline side : wr_en, rd_en, address, write_data -> read_data, ready
//   SRAM side     : sram_addr, sram_dq_out, sram_dq_oe, sram_we_n,
//                   sram_dq_in (read data returned by the device)
//   Modports      : slave  - the controller
//                   master - the environment (pipeline + SRAM device)
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_controller_if;

    logic                                  wr_en;
    logic                                  rd_en;
    logic [31:0]                           address;
    logic [31:0]                           write_data;
    logic [31:0]                           read_data;
    logic                                  ready;
    logic [arm_mem_pkg::SRAM_ADDR_W-1:0]   sram_addr;
    logic [arm_mem_pkg::SRAM_DATA_W-1:0]   sram_dq_out;
    logic [arm_mem_pkg::SRAM_DATA_W-1:0]   sram_dq_in;
    logic                                  sram_dq_oe;
    logic                                  sram_we_n;

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface : sram_controller_if
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : Loadable down-counter timing each SRAM half access.
//   clk          : clock
//   rst          : synchronous active-high reset (count -> 0)
//   i_load       : load i_load_value (has priority over decrement)
//   i_load_value : value to load
//   i_dec        : decrement by one, saturating at zero
//   o_zero       : count is zero (last cycle of the current half)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_value,
    input  wire logic             i_dec,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage bridge from 32-bit loads/stores to a 16-bit
//               asynchronous SRAM. Each access is split into a lower and an
//               upper half of WAIT_CYCLES cycles each; the pipeline is frozen
//               (ready low) until the transfer reaches DONE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sram_controller_if.slave
//              wr_en/rd_en/address/write_data in, read_data/ready out,
//              sram_addr/sram_dq_out/sram_dq_oe/sram_we_n out, sram_dq_in in
// Parameters : WAIT_CYCLES (1..15) cycles per half access
//              BASE_ADDR   byte address mapped to SRAM word 0
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sram_controller_if.slave  bus
);

    // The counter runs WAIT_CYCLES-1 .. 0 so that "zero" marks the last
    // cycle of a half; that cycle both captures read data and changes phase.
    localparam logic [WAIT_CNT_W-1:0] c_wait_load = WAIT_CNT_W'(WAIT_CYCLES - 1);

    sram_state_t            r_state;
    sram_state_t            w_next_state;
    logic                   r_is_write;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_read_data;

    logic                   w_req;
    logic                   w_cnt_load;
    logic                   w_cnt_dec;
    logic                   w_cnt_zero;
    logic                   w_active;
    logic                   w_in_hi;
    logic [SRAM_ADDR_W-2:0] w_word;

    sram_wait_counter #(
        .WIDTH (WAIT_CNT_W)
    ) u_wait_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_cnt_load),
        .i_load_value (c_wait_load),
        .i_dec        (w_cnt_dec),
        .o_zero       (w_cnt_zero)
    );

    // A simultaneous read+write request is serviced as a write.
    assign w_req = bus.wr_en | bus.rd_en;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and counter control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = ST_LO;
                    w_cnt_load   = 1'b1;
                end
            end
            ST_LO: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_HI;
                    w_cnt_load   = 1'b1;
                end else begin
                    w_cnt_dec    = 1'b1;
                end
            end
            ST_HI: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_cnt_dec    = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and read-data capture. Inputs are only sampled in
    // IDLE, so changes while a transfer is in flight are ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_req) begin
                r_is_write <= bus.wr_en;
                r_addr     <= bus.address;
                r_wdata    <= bus.write_data;
            end
            if (!r_is_write && w_cnt_zero) begin
                if (r_state == ST_LO) begin
                    r_read_data[15:0]  <= bus.sram_dq_in;
                end
                if (r_state == ST_HI) begin
                    r_read_data[31:16] <= bus.sram_dq_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. rst masks the strobes combinationally so a reset arriving
    // mid-write stops driving the SRAM in that very cycle.
    // ------------------------------------------------------------------
    assign w_active = ((r_state == ST_LO) || (r_state == ST_HI)) && !rst;
    assign w_in_hi  = (r_state == ST_HI);
    assign w_word   = sram_word_index(r_addr, BASE_ADDR);

    assign bus.ready = rst
                     | (r_state == ST_DONE)
                     | ((r_state == ST_IDLE) & ~w_req);

    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        if (w_active) begin
            bus.sram_addr = {w_word, w_in_hi};
            if (r_is_write) begin
                bus.sram_we_n   = 1'b0;
                bus.sram_dq_oe  = 1'b1;
                bus.sram_dq_out = w_in_hi ? r_wdata[31:16] : r_wdata[15:0];
            end
        end
    end

    assign bus.read_data = r_read_data;

endmodule : sram_controller
`default_nettype wire
